ysyx_22050039_lsu: RTL and testbench

// Load/store unit on the far side of the execute stage: accepts one memory request (address = EXU result,

---
 rtl/ysyx_22050039_lsu_if.sv | 19 +
 rtl/ysyx_22050039_lsu.sv | 86 ++++++++
 tb/tb_ysyx_22050039_lsu.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050039_lsu_if.sv
// ysyx_22050039_lsu_if: single-beat 64-bit data-memory port between the LSU (master) and memory (slave)
interface ysyx_22050039_lsu_if;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_wen;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   modport master (
      output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
      input  mem_ready, mem_rvalid, mem_rdata
   );
   modport slave (
      input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/ysyx_22050039_lsu.sv
// ysyx_22050039_lsu: one-at-a-time load/store unit with lane steering, load extension and misalign detection
module ysyx_22050039_lsu #(
   parameter int XLEN = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req_valid,
   output logic                o_req_ready,
   input  logic                i_req_wen,
   input  logic [1:0]          i_req_size,
   input  logic                i_req_unsigned,
   input  logic [XLEN-1:0]     i_req_addr,
   input  logic [XLEN-1:0]     i_req_wdata,
   ysyx_22050039_lsu_if.master mem,
   output logic                o_rsp_valid,
   output logic                o_rsp_err,
   output logic [XLEN-1:0]     o_rsp_rdata
);
   typedef enum logic [1:0] {IDLE, CMD, RDATA, RESP} state_t;
   state_t          r_state, w_next;
   logic            r_wen, r_uns, r_err;
   logic [1:0]      r_size;
   logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
   logic [2:0]      w_amask;
   logic            w_mis, w_accept;
   logic [7:0]      w_bytes;
   logic [63:0]     w_raw, w_b, w_h, w_w, w_ext;
   assign w_amask  = i_req_size == 2'd0 ? 3'd0 : i_req_size == 2'd1 ? 3'd1 : i_req_size == 2'd2 ? 3'd3 : 3'd7;
   assign w_mis    = |(i_req_addr[2:0] & w_amask);
   assign w_accept = r_state == IDLE && i_req_valid;
   assign w_bytes  = r_size == 2'd0 ? 8'h01 : r_size == 2'd1 ? 8'h03 : r_size == 2'd2 ? 8'h0F : 8'hFF;
   assign w_raw    = mem.mem_rdata >> {r_addr[2:0], 3'b000};
   assign w_b      = r_uns ? 64'(w_raw[7:0])  : {{56{w_raw[7]}},  w_raw[7:0]};
   assign w_h      = r_uns ? 64'(w_raw[15:0]) : {{48{w_raw[15]}}, w_raw[15:0]};
   assign w_w      = r_uns ? 64'(w_raw[31:0]) : {{32{w_raw[31]}}, w_raw[31:0]};
   assign w_ext    = r_size == 2'd0 ? w_b : r_size == 2'd1 ? w_h : r_size == 2'd2 ? w_w : w_raw;
   // state register; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   // next-state: misaligned requests skip memory and go straight to the response
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = i_req_valid ? (w_mis ? RESP : CMD) : IDLE;
         CMD:     w_next = mem.mem_ready ? (r_wen ? RESP : RDATA) : CMD;
         RDATA:   w_next = mem.mem_rvalid ? RESP : RDATA;
         default: w_next = IDLE;
      endcase
   end
   // request capture on accept and load-data capture on read return
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wen   <= 1'b0;
         r_uns   <= 1'b0;
         r_err   <= 1'b0;
         r_size  <= 2'd0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else if (w_accept) begin
         r_wen   <= i_req_wen;
         r_uns   <= i_req_unsigned;
         r_err   <= w_mis;
         r_size  <= i_req_size;
         r_addr  <= i_req_addr;
         r_wdata <= i_req_wdata;
         r_rdata <= '0;
      end else if (r_state == RDATA && mem.mem_rvalid) begin
         r_rdata <= w_ext;
      end
   end
   // outputs: command fields come straight from the captured request so they stay stable while stalled
   always_comb begin
      o_req_ready   = r_state == IDLE;
      mem.mem_valid = r_state == CMD;
      mem.mem_wen   = r_wen;
      mem.mem_addr  = {r_addr[XLEN-1:3], 3'b000};
      mem.mem_wdata = r_wdata << {r_addr[2:0], 3'b000};
      mem.mem_wmask = r_wen ? w_bytes << r_addr[2:0] : 8'h00;
      o_rsp_valid   = r_state == RESP;
      o_rsp_err     = r_state == RESP && r_err;
      o_rsp_rdata   = r_state == RESP ? r_rdata : '0;
   end
endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// tb_ysyx_22050039_lsu: directed scenario tests for the load/store unit
module tb_ysyx_22050039_lsu;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_err;
   logic [63:0] rsp_rdata;
   int          n_vec = 0;
   int          n_err = 0;
   ysyx_22050039_lsu_if bus();
   ysyx_22050039_lsu #(.XLEN(64)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wen(req_wen),
      .i_req_size(req_size), .i_req_unsigned(req_unsigned), .i_req_addr(req_addr),
      .i_req_wdata(req_wdata), .mem(bus.master),
      .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err), .o_rsp_rdata(rsp_rdata)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", req_ready); end
      n_vec++; if (bus.mem_valid !== 1'b0) begin n_err++; $display("FAIL reset_mem_valid got %b want 0", bus.mem_valid); end
      n_vec++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp got %b/%b want 0/0", rsp_valid, rsp_err); end
      n_vec++; if (rsp_rdata !== 64'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
      n_vec++; if (bus.mem_wmask !== 8'h00 || bus.mem_wdata !== 64'h0 || bus.mem_addr !== 64'h0) begin
         n_err++; $display("FAIL reset_mem_data got %h/%h/%h want 0", bus.mem_wmask, bus.mem_wdata, bus.mem_addr); end
   endtask
   task automatic test_store_byte();
      bus.mem_ready = 1'b1;
      req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 64'h80000005; req_wdata = 64'hAB;
      step();
      req_valid = 1'b0;
      n_vec++; if (bus.mem_valid !== 1'b1 || bus.mem_wen !== 1'b1) begin n_err++; $display("FAIL sb_cmd got v=%b w=%b want 1/1", bus.mem_valid, bus.mem_wen); end
      n_vec++; if (bus.mem_addr !== 64'h80000000) begin n_err++; $display("FAIL sb_addr got %h want 80000000", bus.mem_addr); end
      n_vec++; if (bus.mem_wmask !== 8'h20) begin n_err++; $display("FAIL sb_wmask got %h want 20", bus.mem_wmask); end
      n_vec++; if (bus.mem_wdata !== 64'h0000AB0000000000) begin n_err++; $display("FAIL sb_wdata got %h want 0000ab0000000000", bus.mem_wdata); end
      n_vec++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL sb_busy got rdy=%b rsp=%b want 0/0", req_ready, rsp_valid); end
      step();
      n_vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 64'h0) begin
         n_err++; $display("FAIL sb_rsp got v=%b e=%b d=%h want 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
      n_vec++; if (bus.mem_valid !== 1'b0) begin n_err++; $display("FAIL sb_cmd_drop got %b want 0", bus.mem_valid); end
      step();
      n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL sb_idle got rsp=%b rdy=%b want 0/1", rsp_valid, req_ready); end
   endtask
   task automatic test_load_half(input logic uns, input logic [63:0] exp);
      bus.mem_ready = 1'b1;
      req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd1; req_unsigned = uns;
      req_addr = 64'h80000006; req_wdata = 64'hFFFF;
      step();
      req_valid = 1'b0;
      n_vec++; if (bus.mem_valid !== 1'b1 || bus.mem_wen !== 1'b0 || bus.mem_wmask !== 8'h00) begin
         n_err++; $display("FAIL lh_cmd got v=%b w=%b m=%h want 1/0/00", bus.mem_valid, bus.mem_wen, bus.mem_wmask); end
      step();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h8001000000000000;
      n_vec++; if (rsp_valid !== 1'b0 || bus.mem_valid !== 1'b0) begin n_err++; $display("FAIL lh_wait got rsp=%b mv=%b want 0/0", rsp_valid, bus.mem_valid); end
      step();
      bus.mem_rvalid = 1'b0;
      n_vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp || rsp_err !== 1'b0) begin
         n_err++; $display("FAIL lh_rsp u=%b got v=%b d=%h want 1 %h", uns, rsp_valid, rsp_rdata, exp); end
      step();
   endtask
   task automatic test_delayed_word();
      int pulses = 0;
      logic [63:0] seen = '0;
      bus.mem_ready = 1'b0;
      req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 64'h80000004; req_wdata = '0;
      step();
      req_valid = 1'b0; req_addr = 64'h12345678;
      for (int i = 0; i < 3; i++) begin
         n_vec++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 64'h80000000 || bus.mem_wen !== 1'b0 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL lw_hold%0d got v=%b a=%h w=%b rsp=%b want 1/80000000/0/0", i, bus.mem_valid, bus.mem_addr, bus.mem_wen, rsp_valid); end
         step();
      end
      bus.mem_ready = 1'b1;
      step();
      for (int i = 0; i < 2; i++) begin
         n_vec++; if (bus.mem_valid !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL lw_rwait%0d got mv=%b rsp=%b want 0/0", i, bus.mem_valid, rsp_valid); end
         step();
      end
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h7FFFFFFF00000000;
      for (int i = 0; i < 4; i++) begin
         step();
         bus.mem_rvalid = 1'b0;
         if (rsp_valid === 1'b1) begin pulses++; seen = rsp_rdata; end
      end
      n_vec++; if (pulses != 1) begin n_err++; $display("FAIL lw_pulses got %0d want 1", pulses); end
      n_vec++; if (seen !== 64'h000000007FFFFFFF) begin n_err++; $display("FAIL lw_rdata got %h want 000000007fffffff", seen); end
   endtask
   task automatic test_misaligned();
      bus.mem_ready = 1'b1;
      req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
      req_addr = 64'h80000004; req_wdata = 64'hDEADBEEF;
      step();
      req_valid = 1'b0;
      n_vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 64'h0) begin
         n_err++; $display("FAIL mis_rsp got v=%b e=%b d=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
      n_vec++; if (bus.mem_valid !== 1'b0) begin n_err++; $display("FAIL mis_memv got %b want 0", bus.mem_valid); end
      step();
      n_vec++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || bus.mem_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_err++; $display("FAIL mis_after got v=%b e=%b mv=%b rdy=%b want 0/0/0/1", rsp_valid, rsp_err, bus.mem_valid, req_ready); end
   endtask
   task automatic test_reset_rdata();
      bus.mem_ready = 1'b1;
      req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd3; req_addr = 64'h80000000;
      step();
      req_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_vec++; if (req_ready !== 1'b1 || bus.mem_valid !== 1'b0 || rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL rst_rd got rdy=%b mv=%b rsp=%b want 1/0/0", req_ready, bus.mem_valid, rsp_valid); end
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h55;
      step();
      bus.mem_rvalid = 1'b0;
      n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL rst_late got rsp=%b rdy=%b want 0/1", rsp_valid, req_ready); end
      step();
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_late2 got %b want 0", rsp_valid); end
   endtask
   task automatic test_rst_vs_req();
      rst = 1'b1;
      req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd0; req_addr = 64'h80000001; req_wdata = 64'h11;
      step();
      rst = 1'b0; req_valid = 1'b0;
      n_vec++; if (req_ready !== 1'b1 || bus.mem_valid !== 1'b0) begin n_err++; $display("FAIL rst_req got rdy=%b mv=%b want 1/0", req_ready, bus.mem_valid); end
      step();
      n_vec++; if (bus.mem_valid !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_req2 got mv=%b rsp=%b want 0/0", bus.mem_valid, rsp_valid); end
   endtask
   task automatic test_back_to_back();
      int n = 0;
      bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h1122334455667788;
      req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd3; req_unsigned = 1'b1; req_addr = 64'h80000008;
      step();
      n_vec++; if (req_ready !== 1'b0 || bus.mem_valid !== 1'b1) begin n_err++; $display("FAIL b2b_cmd got rdy=%b mv=%b want 0/1", req_ready, bus.mem_valid); end
      step();
      n_vec++; if (req_ready !== 1'b0 || bus.mem_valid !== 1'b0 || rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL b2b_rdata got rdy=%b mv=%b rsp=%b want 0/0/0", req_ready, bus.mem_valid, rsp_valid); end
      step();
      n_vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h1122334455667788 || req_ready !== 1'b0) begin
         n_err++; $display("FAIL b2b_rsp got v=%b d=%h rdy=%b want 1/1122334455667788/0", rsp_valid, rsp_rdata, req_ready); end
      step();
      n_vec++; if (req_ready !== 1'b1 || bus.mem_valid !== 1'b0 || rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL b2b_idle got rdy=%b mv=%b rsp=%b want 1/0/0", req_ready, bus.mem_valid, rsp_valid); end
      step();
      n_vec++; if (req_ready !== 1'b0 || bus.mem_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second got rdy=%b mv=%b want 0/1", req_ready, bus.mem_valid); end
      req_valid = 1'b0;
      while (req_ready !== 1'b1 && n < 10) begin step(); n++; end
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_drain timeout rdy=%b want 1", req_ready); end
      bus.mem_rvalid = 1'b0;
   endtask
   initial begin
      bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      test_reset();
      test_store_byte();
      test_load_half(1'b0, 64'hFFFFFFFFFFFF8001);
      test_load_half(1'b1, 64'h0000000000008001);
      test_delayed_word();
      test_misaligned();
      test_reset_rdata();
      test_rst_vs_req();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
